// File: rtl/cntr_req_arbiter.sv
// cntr_req_arbiter
// Involuntary-counter request cell. NCHAN asynchronous plus/minus pulse pairs
// are synchronized and rising-edge detected. Each channel keeps one pending
// request in one direction. An opposite pulse cancels a pending request. A
// repeated same-direction pulse before service raises a sticky miss flag.
// On each counter slot one pending request, lowest channel first, is moved
// into a grant register that the sequencer takes with a valid/ack handshake.
//
// Ports
//   clk, rst                  : clock, synchronous active-high reset
//   plus_in, minus_in         : async pulse inputs, one bit per channel
//   chan_en                   : channel enable; 0 flushes and ignores channel
//   slot                      : one-cycle counter-slot strobe
//   grant_valid/_chan/_minus  : grant register (minus=1 means decrement)
//   grant_ack                 : sequencer has taken the grant
//   pend_plus, pend_minus     : pending request status
//   miss, miss_clr            : sticky missed-pulse flags and their clears

module cntr_req_arbiter #(
   parameter int NCHAN       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int IDXW        = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCHAN-1:0] plus_in,
   input  logic [NCHAN-1:0] minus_in,
   input  logic [NCHAN-1:0] chan_en,
   input  logic             slot,
   output logic             grant_valid,
   output logic [IDXW-1:0]  grant_chan,
   output logic             grant_minus,
   input  logic             grant_ack,
   output logic [NCHAN-1:0] pend_plus,
   output logic [NCHAN-1:0] pend_minus,
   output logic [NCHAN-1:0] miss,
   input  logic [NCHAN-1:0] miss_clr
);

   // Synchronizer chains and edge history
   logic [NCHAN-1:0] plus_sync_q  [SYNC_STAGES];
   logic [NCHAN-1:0] minus_sync_q [SYNC_STAGES];
   logic [NCHAN-1:0] plus_hist_q;
   logic [NCHAN-1:0] minus_hist_q;

   // Request and grant state
   logic [NCHAN-1:0] pend_plus_q,  pend_plus_d;
   logic [NCHAN-1:0] pend_minus_q, pend_minus_d;
   logic [NCHAN-1:0] miss_q,       miss_d;
   logic             grant_valid_q, grant_valid_d;
   logic [IDXW-1:0]  grant_chan_q,  grant_chan_d;
   logic             grant_minus_q, grant_minus_d;

   // Combinational helpers
   logic [NCHAN-1:0] plus_edge_s;
   logic [NCHAN-1:0] minus_edge_s;
   logic [NCHAN-1:0] req_s;
   logic [NCHAN-1:0] sel_oh_s;
   logic [IDXW-1:0]  sel_idx_s;
   logic             sel_minus_s;
   logic             sel_found_s;
   logic             issue_s;
   logic [NCHAN-1:0] clr_mask_s;
   logic [NCHAN-1:0] pbase_s;
   logic [NCHAN-1:0] mbase_s;
   logic [NCHAN-1:0] miss_set_s;

   // History holds the previous synchronized level, so a level held across
   // reset release still gives exactly one edge once it reaches the chain end.
   assign plus_edge_s  = plus_sync_q[SYNC_STAGES-1]  & ~plus_hist_q;
   assign minus_edge_s = minus_sync_q[SYNC_STAGES-1] & ~minus_hist_q;

   // Synchronizer shift chains and edge-history registers
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            plus_sync_q[s]  <= '0;
            minus_sync_q[s] <= '0;
         end
         plus_hist_q  <= '0;
         minus_hist_q <= '0;
      end else begin
         plus_sync_q[0]  <= plus_in;
         minus_sync_q[0] <= minus_in;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            plus_sync_q[s]  <= plus_sync_q[s-1];
            minus_sync_q[s] <= minus_sync_q[s-1];
         end
         plus_hist_q  <= plus_sync_q[SYNC_STAGES-1];
         minus_hist_q <= minus_sync_q[SYNC_STAGES-1];
      end
   end

   // Lowest-index enabled pending channel
   always_comb begin
      req_s       = (pend_plus_q | pend_minus_q) & chan_en;
      sel_found_s = 1'b0;
      sel_idx_s   = '0;
      sel_minus_s = 1'b0;
      sel_oh_s    = '0;
      for (int i = 0; i < NCHAN; i++) begin
         if (req_s[i] && !sel_found_s) begin
            sel_found_s = 1'b1;
            sel_idx_s   = IDXW'(i);
            sel_minus_s = pend_minus_q[i];
            sel_oh_s[i] = 1'b1;
         end else begin
            sel_found_s = sel_found_s;
         end
      end
   end

   // A slot is only honoured while the grant register is empty
   assign issue_s    = slot & ~grant_valid_q & sel_found_s;
   assign clr_mask_s = issue_s ? sel_oh_s : '0;

   // Edges are applied after the issue clear, so a fresh edge on the channel
   // just granted starts a new request instead of flagging a miss.
   assign pbase_s = pend_plus_q  & ~clr_mask_s;
   assign mbase_s = pend_minus_q & ~clr_mask_s;

   // Per-channel pending update and miss detection
   always_comb begin
      pend_plus_d  = pbase_s;
      pend_minus_d = mbase_s;
      miss_set_s   = '0;
      for (int i = 0; i < NCHAN; i++) begin
         if (!chan_en[i]) begin
            pend_plus_d[i]  = 1'b0;
            pend_minus_d[i] = 1'b0;
         end else if (plus_edge_s[i] && minus_edge_s[i]) begin
            pend_plus_d[i]  = pbase_s[i];
         end else if (plus_edge_s[i] && mbase_s[i]) begin
            pend_minus_d[i] = 1'b0;
         end else if (minus_edge_s[i] && pbase_s[i]) begin
            pend_plus_d[i]  = 1'b0;
         end else if (plus_edge_s[i] && pbase_s[i]) begin
            miss_set_s[i]   = 1'b1;
         end else if (minus_edge_s[i] && mbase_s[i]) begin
            miss_set_s[i]   = 1'b1;
         end else if (plus_edge_s[i]) begin
            pend_plus_d[i]  = 1'b1;
         end else if (minus_edge_s[i]) begin
            pend_minus_d[i] = 1'b1;
         end else begin
            pend_plus_d[i]  = pbase_s[i];
         end
      end
      // Set beats clear when both land in the same cycle
      miss_d = (miss_q & ~miss_clr) | miss_set_s;
   end

   // Grant register next state: load on issue, drop on ack, else hold
   always_comb begin
      grant_valid_d = grant_valid_q;
      grant_chan_d  = grant_chan_q;
      grant_minus_d = grant_minus_q;
      if (issue_s) begin
         grant_valid_d = 1'b1;
         grant_chan_d  = sel_idx_s;
         grant_minus_d = sel_minus_s;
      end else if (grant_valid_q && grant_ack) begin
         grant_valid_d = 1'b0;
      end else begin
         grant_valid_d = grant_valid_q;
      end
   end

   // Request, miss and grant state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_plus_q   <= '0;
         pend_minus_q  <= '0;
         miss_q        <= '0;
         grant_valid_q <= 1'b0;
         grant_chan_q  <= '0;
         grant_minus_q <= 1'b0;
      end else begin
         pend_plus_q   <= pend_plus_d;
         pend_minus_q  <= pend_minus_d;
         miss_q        <= miss_d;
         grant_valid_q <= grant_valid_d;
         grant_chan_q  <= grant_chan_d;
         grant_minus_q <= grant_minus_d;
      end
   end

   assign grant_valid = grant_valid_q;
   assign grant_chan  = grant_chan_q;
   assign grant_minus = grant_minus_q;
   assign pend_plus   = pend_plus_q;
   assign pend_minus  = pend_minus_q;
   assign miss        = miss_q;

endmodule
